rc4_encryption_core: RTL and testbench

Encrypts a fixed-length plaintext message under a 24-bit RC4 key and writes the ciphertext to a RAM, producing exactly the image the decryption cores read from the message ROM. It runs the three RC4 phases in sequence against an external 256×8 S-memory: S initialisation, key scheduling and PRGA with XOR. It starts on a one-cycle `start` pulse and reports completion with a one-cycle `done` pulse. The block sits alongside the decryption cores and is used to generate ciphertext images and to run round-trip self-checks.

---
 rtl/rc4_pkg.sv | 42 ++++
 rtl/rc4_encryption_core_if.sv | 35 +++
 rtl/rc4_encryption_core.sv | 176 +++++++++++++++++
 tb/tb_rc4_encryption_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 encryption core.
// States, the KSA/PRGA phase flag and the key-byte selector.
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        READ_I,
        LATCH_I,
        READ_J,
        LATCH_J,
        WRITE_I,
        WRITE_J,
        READ_F,
        LATCH_F,
        WRITE_CT,
        DONE
    } state_t;

    typedef enum logic {
        PH_KSA,
        PH_PRGA
    } phase_t;

    localparam int S_SIZE    = 256;
    localparam int KEY_BYTES = 3;

    // Byte 0 is the most significant byte of the key.
    function automatic logic [7:0] key_byte(
        input logic [23:0] key,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = key[23:16];
            2'd1:    b = key[15:8];
            default: b = key[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rc4_encryption_core_if.sv
// Bus bundle between the RC4 encryption core and its parent:
// control handshake, S-memory, plaintext ROM and ciphertext RAM.
interface rc4_encryption_core_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [23:0]       key;
    logic              busy;
    logic              done;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [ADDR_W-1:0] pt_address;
    logic [7:0]        pt_q;
    logic [ADDR_W-1:0] ct_address;
    logic [7:0]        ct_data;
    logic              ct_wren;

    modport master (
        input  start, key, s_q, pt_q,
        output busy, done,
        output s_address, s_data, s_wren,
        output pt_address,
        output ct_address, ct_data, ct_wren
    );

    modport slave (
        output start, key, s_q, pt_q,
        input  busy, done,
        input  s_address, s_data, s_wren,
        input  pt_address,
        input  ct_address, ct_data, ct_wren
    );
endinterface

// File: rtl/rc4_encryption_core.sv
// RC4 encryption core: S init, key scheduling, then PRGA XOR
// of MSG_LEN plaintext bytes into the ciphertext RAM.
module rc4_encryption_core
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    rc4_encryption_core_if.master bus
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);
    localparam logic [7:0]        I_LAST = 8'(S_SIZE - 1);
    localparam logic [1:0]        KX_LAST = 2'(KEY_BYTES - 1);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        f_q, f_d;
    logic [7:0]        p_q, p_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [1:0]        kx_q, kx_d;
    logic [23:0]       key_q, key_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= PH_KSA;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            p_q     <= '0;
            k_q     <= '0;
            kx_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            p_q     <= p_d;
            k_q     <= k_d;
            kx_q    <= kx_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        i_d            = i_q;
        j_d            = j_q;
        si_d           = si_q;
        sj_d           = sj_q;
        f_d            = f_q;
        p_d            = p_q;
        k_d            = k_q;
        kx_d           = kx_q;
        key_d          = key_q;
        bus.busy       = (state_q != IDLE);
        bus.done       = 1'b0;
        bus.s_address  = '0;
        bus.s_data     = '0;
        bus.s_wren     = 1'b0;
        bus.pt_address = '0;
        bus.ct_address = '0;
        bus.ct_data    = '0;
        bus.ct_wren    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    kx_d    = '0;
                    phase_d = PH_KSA;
                    state_d = INIT;
                end
            end
            INIT: begin
                bus.s_address = i_q;
                bus.s_data    = i_q;
                bus.s_wren    = 1'b1;
                i_d           = i_q + 8'd1;
                if (i_q == I_LAST) begin
                    j_d     = '0;
                    state_d = READ_I;
                end
            end
            READ_I: begin
                bus.s_address = i_q;
                state_d       = LATCH_I;
            end
            LATCH_I: begin
                si_d = bus.s_q;
                if (phase_q == PH_KSA)
                    j_d = j_q + bus.s_q + key_byte(key_q, kx_q);
                else
                    j_d = j_q + bus.s_q;
                state_d = READ_J;
            end
            READ_J: begin
                bus.s_address = j_q;
                state_d       = LATCH_J;
            end
            LATCH_J: begin
                sj_d    = bus.s_q;
                state_d = WRITE_I;
            end
            WRITE_I: begin
                bus.s_address = i_q;
                bus.s_data    = sj_q;
                bus.s_wren    = 1'b1;
                state_d       = WRITE_J;
            end
            WRITE_J: begin
                bus.s_address = j_q;
                bus.s_data    = si_q;
                bus.s_wren    = 1'b1;
                if (phase_q == PH_PRGA) begin
                    state_d = READ_F;
                end else begin
                    i_d     = i_q + 8'd1;
                    kx_d    = (kx_q == KX_LAST) ? 2'd0 : kx_q + 2'd1;
                    state_d = READ_I;
                    // PRGA starts at i=0 and pre-increments, so byte 0 uses i=1.
                    if (i_q == I_LAST) begin
                        phase_d = PH_PRGA;
                        i_d     = 8'd1;
                        j_d     = '0;
                    end
                end
            end
            READ_F: begin
                bus.s_address  = si_q + sj_q;
                bus.pt_address = k_q;
                state_d        = LATCH_F;
            end
            LATCH_F: begin
                f_d     = bus.s_q;
                p_d     = bus.pt_q;
                state_d = WRITE_CT;
            end
            WRITE_CT: begin
                bus.ct_address = k_q;
                bus.ct_data    = f_q ^ p_q;
                bus.ct_wren    = 1'b1;
                k_d            = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    state_d = READ_I;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_encryption_core.sv
// Scoreboard bench for rc4_encryption_core with behavioural
// S-memory, plaintext ROM and ciphertext RAM.
module tb_rc4_encryption_core;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;
    localparam int T_DONE  = 256 + 1536 + 9 * MSG_LEN + 1;
    localparam int T_CT0   = 1801;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rc4_encryption_core_if #(.ADDR_W(ADDR_W)) bus ();

    rc4_encryption_core #(
        .MSG_LEN(MSG_LEN),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [MSG_LEN];
    logic [7:0] ct_mem [MSG_LEN];
    logic [7:0] exp_ct [MSG_LEN];
    logic [7:0] ref_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9,
                               8'h40, 8'hAF, 8'h0A, 8'hD3};

    always @(posedge clk) begin
        if (bus.s_wren) s_mem[bus.s_address] <= bus.s_data;
        if (bus.ct_wren) ct_mem[bus.ct_address] <= bus.ct_data;
        bus.s_q  <= s_mem[bus.s_address];
        bus.pt_q <= pt_mem[bus.pt_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vecs = 0;
    int errs = 0;
    int c0 = 0;
    int s_wr_cnt = 0;
    int ct_wr_cnt = 0;
    int done_cnt = 0;
    logic [12:0] sb_q [$];

    // Monitor: scoreboard pops on each ciphertext write.
    always @(negedge clk) begin
        logic [12:0] e;
        int rel;
        if (!reset) begin
            if (bus.s_wren && bus.ct_wren) begin
                errs++;
                $display("FAIL wren_overlap s_wren=1 ct_wren=1 at cycle %0d",
                         cyc - c0);
            end
            if (bus.s_wren) s_wr_cnt++;
            if (bus.done) done_cnt++;
            if (bus.ct_wren) begin
                ct_wr_cnt++;
                vecs++;
                rel = cyc - c0;
                if (sb_q.size() == 0) begin
                    errs++;
                    $display("FAIL ct_unexpected addr=%0d data=%h expected none",
                             bus.ct_address, bus.ct_data);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.ct_address, bus.ct_data} !== e ||
                        rel != T_CT0 + 9 * int'(e[12:8])) begin
                        errs++;
                        $display("FAIL ct_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                                 bus.ct_address, bus.ct_data, rel, e[12:8], e[7:0],
                                 T_CT0 + 9 * int'(e[12:8]));
                    end
                end
            end
        end
    end

    task automatic model_run(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int n = 0; n < 256; n++) s[n] = n[7:0];
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            t = s[n];
            s[n] = s[j];
            s[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        for (int n = 0; n < MSG_LEN; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            t = s[i] + s[j];
            exp_ct[n] = s[t] ^ pt_mem[n];
            sb_q.push_back({n[ADDR_W-1:0], exp_ct[n]});
        end
    endtask

    task automatic load_text();
        string msg = "Plaintext";
        for (int n = 0; n < MSG_LEN; n++)
            pt_mem[n] = (n < msg.len()) ? msg[n] : 8'h00;
    endtask

    task automatic run_enc(input logic [23:0] key, input string tag);
        int done_rel;
        logic seen;
        model_run(key);
        @(negedge clk);
        bus.key   = key;
        bus.start = 1'b1;
        c0        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        done_rel  = -1;
        seen      = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            if (bus.done) begin
                done_rel = cyc - c0;
                seen     = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        vecs++;
        if (done_rel != T_DONE) begin
            errs++;
            $display("FAIL %s done_cycle got %0d expected %0d", tag, done_rel, T_DONE);
        end
        @(negedge clk);
        vecs++;
        if (sb_q.size() != 0) begin
            errs++;
            $display("FAIL %s sb_leftover got %0d expected 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        vecs++;
        if ({bus.busy, bus.done, bus.s_address, bus.s_data, bus.s_wren,
             bus.pt_address, bus.ct_address, bus.ct_data, bus.ct_wren} !== '0) begin
            errs++;
            $display("FAIL %s outputs busy=%b done=%b s_a=%h s_d=%h s_we=%b pt_a=%h ct_a=%h ct_d=%h ct_we=%b expected all 0",
                     tag, bus.busy, bus.done, bus.s_address, bus.s_data, bus.s_wren,
                     bus.pt_address, bus.ct_address, bus.ct_data, bus.ct_wren);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.key   = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_vector();
        load_text();
        run_enc(24'h4B6579, "vector");
        for (int n = 0; n < 9; n++) begin
            vecs++;
            if (ct_mem[n] !== ref_ct[n]) begin
                errs++;
                $display("FAIL vector ct[%0d] got %h expected %h", n, ct_mem[n], ref_ct[n]);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [7:0] orig [MSG_LEN];
        for (int n = 0; n < MSG_LEN; n++) begin
            orig[n]   = 8'($urandom_range(0, 255));
            pt_mem[n] = orig[n];
        end
        run_enc(24'h1A2B3C, "rt_enc");
        for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = ct_mem[n];
        run_enc(24'h1A2B3C, "rt_dec");
        for (int n = 0; n < MSG_LEN; n++) begin
            vecs++;
            if (ct_mem[n] !== orig[n]) begin
                errs++;
                $display("FAIL round_trip byte[%0d] got %h expected %h", n, ct_mem[n], orig[n]);
            end
        end
    endtask

    task automatic test_timing();
        int sw0, cw0, dn0;
        logic exp_busy;
        for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = 8'($urandom_range(0, 255));
        model_run(24'h4B6579);
        @(negedge clk);
        sw0     = s_wr_cnt;
        cw0     = ct_wr_cnt;
        dn0     = done_cnt;
        bus.key = 24'h4B6579;
        c0      = cyc;
        for (int r = 0; r <= 2100; r++) begin
            bus.start = (r == 0 || r == 50 || r == 2081);
            exp_busy  = (r >= 1 && r <= T_DONE);
            vecs++;
            if (bus.busy !== exp_busy || bus.done !== (r == T_DONE)) begin
                errs++;
                $display("FAIL timing cyc=%0d busy=%b done=%b expected busy=%b done=%b",
                         r, bus.busy, bus.done, exp_busy, r == T_DONE);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        @(negedge clk);
        vecs++;
        if (s_wr_cnt - sw0 != 256 + 512 + 64 || ct_wr_cnt - cw0 != MSG_LEN ||
            done_cnt - dn0 != 1) begin
            errs++;
            $display("FAIL write_counts s=%0d ct=%0d done=%0d expected s=832 ct=%0d done=1",
                     s_wr_cnt - sw0, ct_wr_cnt - cw0, done_cnt - dn0, MSG_LEN);
        end
        vecs++;
        if (sb_q.size() != 0) begin
            errs++;
            $display("FAIL timing sb_leftover got %0d expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_abort();
        int sw0, cw0, dn0;
        load_text();
        model_run(24'h4B6579);
        @(negedge clk);
        bus.key   = 24'h4B6579;
        bus.start = 1'b1;
        c0        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc - c0 < 1000) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("abort_c0");
        @(negedge clk);
        check_idle_outputs("abort_c1");
        sb_q.delete();
        reset = 1'b0;
        sw0   = s_wr_cnt;
        cw0   = ct_wr_cnt;
        dn0   = done_cnt;
        repeat (40) @(negedge clk);
        vecs++;
        if (s_wr_cnt != sw0 || ct_wr_cnt != cw0 || done_cnt != dn0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL abort_quiet s=%0d ct=%0d done=%0d busy=%b expected 0 0 0 0",
                     s_wr_cnt - sw0, ct_wr_cnt - cw0, done_cnt - dn0, bus.busy);
        end
        run_enc(24'h4B6579, "after_abort");
        for (int n = 0; n < 9; n++) begin
            vecs++;
            if (ct_mem[n] !== ref_ct[n]) begin
                errs++;
                $display("FAIL after_abort ct[%0d] got %h expected %h", n, ct_mem[n], ref_ct[n]);
            end
        end
    endtask

    task automatic test_zero_key();
        for (int n = 0; n < MSG_LEN; n++) pt_mem[n] = 8'h00;
        run_enc(24'h000000, "zero_key");
        for (int n = 0; n < MSG_LEN; n++) begin
            vecs++;
            if (ct_mem[n] !== exp_ct[n]) begin
                errs++;
                $display("FAIL zero_key ks[%0d] got %h expected %h", n, ct_mem[n], exp_ct[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vector();
        test_round_trip();
        test_timing();
        test_reset_abort();
        test_zero_key();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
